piso_stream: RTL
================

Name: piso_stream

Overview:
Parametrised parallel-in/serial-out shift register with load handshake, bit counter and frame-done pulse.
- Successor to the fixed 4-bit PISO (`q`, `ip`, `i0`, `s`, `clk`). Adds selectable width and shift direction, a ready/load handshake, an output-valid qualifier and asynchronous reset.
- Serialises one WIDTH-bit word per frame toward a serial sink, e.g. the lab UART/serial link blocks.

Parameters:
- WIDTH, 4: parallel word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  request to capture ip; accepted only when ready=1.
- ip  input  WIDTH  parallel word, sampled on the accepting edge.
- i0  input  1  serial fill bit, shifted into the vacated end on every shift.
- ready  output  1  block can accept load this cycle.
- q  output  1  current serial output bit; forced 0 when q_valid=0.
- q_valid  output  1  q carries a frame bit this cycle.
- done  output  1  one-cycle pulse coincident with the last bit of a frame.

Behaviour:
- Single clock `clk`. Reset `rst` is asynchronous and active-high; it clears all state immediately, independent of `clk`.
- Reset values:
  - state = IDLE, shift register = 0, counter = 0.
  - ready = 1, q = 0, q_valid = 0, done = 0.
- Internal state:
  - shift register sr[WIDTH-1:0].
  - bit counter cnt, $clog2(WIDTH) bits.
  - 2-state FSM: IDLE, SHIFT.
- IDLE:
  - ready = 1, q_valid = 0, q = 0.
  - On a clk edge with load=1: sr <= ip, cnt <= 0, state <= SHIFT.
  - load=0: remain in IDLE; sr holds.
- SHIFT:
  - ready = 0 (see Optional Feature); q_valid = 1.
  - q = sr[WIDTH-1] if MSB_FIRST, else sr[0]. q is combinational from sr; the first bit appears in the cycle after the accepting edge (latency 1).
  - Each edge, MSB_FIRST=1: sr <= {sr[WIDTH-2:0], i0}.
  - Each edge, MSB_FIRST=0: sr <= {i0, sr[WIDTH-1:1]}.
  - Each edge: cnt <= cnt + 1.
  - done = 1 while cnt == WIDTH-1 (last bit). On that edge state <= IDLE and cnt <= 0.
  - A frame therefore occupies exactly WIDTH cycles with q_valid=1.
- Boundaries:
  - load while ready=0: ignored; the frame in progress is not disturbed and ip is not sampled.
  - rst asserted mid-frame: frame aborted, reset values apply at once. First legal load is on the first clk edge after rst deasserts.
  - rst and load together: rst wins.
  - cnt never exceeds WIDTH-1; there is no wrap beyond a frame.
  - i0 only affects sr contents and never reaches q within the same frame. After WIDTH shifts, sr is entirely i0 history.
  - ip changing while not accepted: no effect.

Optional Feature:
- Macro: PISO_STREAM_CONT_EN.
- Defined (gapless streaming):
  - ready = 1 also during the last-bit cycle (cnt == WIDTH-1).
  - load=1 on that edge loads sr <= ip, cnt <= 0, state stays SHIFT.
  - The next frame's first bit follows the previous last bit with no idle cycle; q_valid stays 1 and done pulses once per frame.
- Not defined:
  - ready = 0 throughout SHIFT.
  - At least one IDLE cycle (q_valid=0) separates consecutive frames.

Test Plan:
- WIDTH=4, MSB_FIRST=1, ip=4'b1101, load pulsed 1 cycle -> q = 1,1,0,1 on the next 4 cycles; q_valid=1 for exactly those 4 cycles; done=1 only on the 4th; ready returns to 1 after.
- WIDTH=4, MSB_FIRST=0, ip=4'b1101 -> q = 1,0,1,1; done on the 4th bit.
- WIDTH=8, ip=8'hA5, load held high for the whole frame, ip changed to 8'hFF mid-frame -> q = 1,0,1,0,0,1,0,1 unaffected. Without the macro: next frame (8'hFF) starts after one idle cycle.
- rst asserted asynchronously (between edges) after the 2nd bit of 4'b1101 -> q, q_valid and done drop to 0 immediately, ready=1; a new load of 4'b0110 then yields 0,1,1,0.
- With PISO_STREAM_CONT_EN: WIDTH=4, frames 4'b1001 then 4'b0111, second load asserted on the last-bit cycle -> q = 1,0,0,1,0,1,1,1 contiguously; q_valid is high for all 8 cycles; done pulses on bits 4 and 8.
- rst=1 and load=1 on the same edge, then rst released -> no frame starts; q_valid stays 0 until a subsequent load.

Source files
------------

// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - parametrised PISO shifter with load handshake, bit counter and frame-done pulse
// Optional gapless back-to-back frames: define PISO_STREAM_CONT_EN.
module piso_stream #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] ip,
    input  logic             i0,
    output logic             ready,
    output logic             q,
    output logic             q_valid,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             q_valid_q, q_valid_d;
    logic             done_q, done_d;
    logic             accept;

    assign accept = load & ready_q;

    always_comb begin
        if (MSB_FIRST) begin
            sr_shift = {sr_q[WIDTH-2:0], i0};
        end else begin
            sr_shift = {i0, sr_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sr_d    = ip;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d = sr_shift;
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef PISO_STREAM_CONT_EN
                    if (accept) begin
                        sr_d = ip;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with sr_q.
        q_valid_d = (state_d == SHIFT);
        done_d    = (state_d == SHIFT) && (cnt_d == LAST);
`ifdef PISO_STREAM_CONT_EN
        ready_d   = (state_d == IDLE) || done_d;
`else
        ready_d   = (state_d == IDLE);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            q_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            q_valid_q <= q_valid_d;
            done_q    <= done_d;
        end
    end

    assign ready   = ready_q;
    assign q_valid = q_valid_q;
    assign done    = done_q;
    assign q       = q_valid_q & (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);

endmodule
